pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It combines three inputs into one consistent set of pipeline-register enables and bubble/flush controls each cycle:
- the load-use stall request from hazard detection,
- the taken-branch indication from ID,
- the data-memory busy signal from MEM.

It also runs a multi-cycle flush sequence after taken branches and keeps saturating stall/flush event counters and a sticky stall-watchdog flag for debug.

---
 rtl/pipeline_stall_controller.sv | 162 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: merges the load-use stall request, the taken-branch indication and
// the data-memory busy signal into one consistent set of pipeline-register
// enables and bubble/flush controls. It runs a multi-cycle IF/ID flush after
// taken branches and keeps saturating stall/flush counters and a sticky
// stall-watchdog flag for debug.
//
// Ports:
//   i_clk           pipeline clock, rising edge
//   i_rst           asynchronous, active-high reset
//   i_load_use      load-use hazard detected
//   i_br_taken      branch in ID resolved taken this cycle
//   i_mem_busy      data memory not ready, MEM stage must hold
//   i_clr_cnt       synchronous clear of counters and hazard flag
//   o_pc_write      PC load enable
//   o_if_id_write   IF/ID register write enable
//   o_if_id_flush   IF/ID register cleared to NOP on this edge
//   o_id_ex_bubble  zero ID/EX control fields
//   o_pipe_hold     freeze ID/EX, EX/MEM, MEM/WB
//   o_in_flush      sequencer is in the FLUSH state
//   o_stall_cnt     saturating count of cycles with o_pc_write=0
//   o_flush_cnt     saturating count of taken-branch flush sequences
//   o_haz_err       sticky: load-use held STALL_LIMIT consecutive non-busy cycles
module pipeline_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int STALL_LIMIT  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_use,
  input  logic             i_br_taken,
  input  logic             i_mem_busy,
  input  logic             i_clr_cnt,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_pipe_hold,
  output logic             o_in_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_haz_err
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [2:0]       LP_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0]       LP_LIMIT      = 4'(STALL_LIMIT);
  localparam logic [3:0]       LP_LIMIT_M1   = 4'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_CNT_MAX    = {CNT_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_flush_left;
  logic [3:0]       r_streak;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_haz_err;

  logic w_run;
  logic w_load_stall;
  logic w_branch_start;
  logic w_streak_clear;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_pipe_hold;

  // Qualified events; memBusy masks everything, loadUse masks brTaken.
  assign w_run          = (r_state == ST_RUN);
  assign w_load_stall   = w_run & ~i_mem_busy & i_load_use;
  assign w_streak_clear = w_run & ~i_mem_busy & ~i_load_use;
  assign w_branch_start = w_streak_clear & i_br_taken;

  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_pipe_hold    = 1'b0;
    if (i_mem_busy) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_hold   = 1'b1;
    end else if (!w_run) begin
      // FLUSH squashes whatever IF/ID would capture; loadUse/brTaken ignored.
      w_if_id_flush = 1'b1;
    end else if (i_load_use) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_bubble = 1'b1;
    end else if (i_br_taken) begin
      w_if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_flush_left <= 3'd0;
      r_streak     <= 4'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_haz_err    <= 1'b0;
    end else begin
      // Sequencer: busy cycles freeze it so they extend the flush window.
      if (!i_mem_busy) begin
        if (w_run) begin
          if (w_branch_start && (FLUSH_CYCLES > 1)) begin
            r_state      <= ST_FLUSH;
            r_flush_left <= LP_FLUSH_INIT;
          end
        end else begin
          r_flush_left <= r_flush_left - 3'd1;
          if (r_flush_left == 3'd1) begin
            r_state <= ST_RUN;
          end
        end
      end

      // Debug counters; clear has priority over any same-cycle increment.
      if (i_clr_cnt) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
        r_streak    <= 4'd0;
        r_haz_err   <= 1'b0;
      end else begin
        if (!w_pc_write && (r_stall_cnt != LP_CNT_MAX)) begin
          r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
        end
        if (w_branch_start && (r_flush_cnt != LP_CNT_MAX)) begin
          r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
        end
        if (w_load_stall) begin
          // Streak parks at the limit so it can never wrap back below it.
          if (r_streak != LP_LIMIT) begin
            r_streak <= r_streak + 4'd1;
          end
          if (r_streak >= LP_LIMIT_M1) begin
            r_haz_err <= 1'b1;
          end
        end else if (w_streak_clear) begin
          r_streak <= 4'd0;
        end
      end
    end
  end

  assign o_pc_write     = w_pc_write;
  assign o_if_id_write  = w_if_id_write;
  assign o_if_id_flush  = w_if_id_flush;
  assign o_id_ex_bubble = w_id_ex_bubble;
  assign o_pipe_hold    = w_pipe_hold;
  assign o_in_flush     = (r_state == ST_FLUSH);
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;
  assign o_haz_err      = r_haz_err;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int FC_A = 3;
  localparam int W_A  = 4;
  localparam int SL_A = 4;
  localparam int FC_B = 1;
  localparam int W_B  = 16;
  localparam int SL_B = 2;
  localparam int CMAX_A = (1 << W_A) - 1;
  localparam int CMAX_B = (1 << W_B) - 1;

  logic clk = 1'b0;
  logic rst;
  logic lu, br, mb, clr;

  logic           a_pc, a_ifw, a_iff, a_bub, a_hold, a_inf, a_haz;
  logic [W_A-1:0] a_sc, a_fc;
  logic           b_pc, b_ifw, b_iff, b_bub, b_hold, b_inf, b_haz;
  logic [W_B-1:0] b_sc, b_fc;

  pipeline_stall_controller #(.FLUSH_CYCLES(FC_A), .CNT_W(W_A), .STALL_LIMIT(SL_A)) u_a (
    .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_br_taken(br), .i_mem_busy(mb),
    .i_clr_cnt(clr), .o_pc_write(a_pc), .o_if_id_write(a_ifw), .o_if_id_flush(a_iff),
    .o_id_ex_bubble(a_bub), .o_pipe_hold(a_hold), .o_in_flush(a_inf),
    .o_stall_cnt(a_sc), .o_flush_cnt(a_fc), .o_haz_err(a_haz)
  );

  pipeline_stall_controller #(.FLUSH_CYCLES(FC_B), .CNT_W(W_B), .STALL_LIMIT(SL_B)) u_b (
    .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_br_taken(br), .i_mem_busy(mb),
    .i_clr_cnt(clr), .o_pc_write(b_pc), .o_if_id_write(b_ifw), .o_if_id_flush(b_iff),
    .o_id_ex_bubble(b_bub), .o_pipe_hold(b_hold), .o_in_flush(b_inf),
    .o_stall_cnt(b_sc), .o_flush_cnt(b_fc), .o_haz_err(b_haz)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: pend = flush cycles still owed (0 means RUN); counters are plain ints.
  typedef struct {
    int pend;
    int sc;
    int fc;
    int streak;
    bit haz;
  } model_t;

  model_t m_a, m_b;

  // Returns {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}.
  function automatic logic [4:0] exp_ctl(input int pend, input bit l, input bit b, input bit m);
    if (m)        return 5'b00001;
    if (pend > 0) return 5'b11100;
    if (l)        return 5'b00010;
    if (b)        return 5'b11100;
    return 5'b11000;
  endfunction

  function automatic model_t step(input model_t s, input int fcyc, input int cmax, input int slim,
                                  input bit l, input bit b, input bit m, input bit c);
    model_t n;
    logic [4:0] ctl;
    n = s;
    ctl = exp_ctl(s.pend, l, b, m);
    if (!ctl[4] && n.sc < cmax) n.sc = n.sc + 1;
    if (!m) begin
      if (s.pend > 0) begin
        n.pend = s.pend - 1;
      end else if (l) begin
        n.streak = s.streak + 1;
        if (n.streak >= slim) n.haz = 1'b1;
      end else begin
        n.streak = 0;
        if (b) begin
          if (n.fc < cmax) n.fc = n.fc + 1;
          n.pend = fcyc - 1;
        end
      end
    end
    if (c) begin
      n.sc = 0;
      n.fc = 0;
      n.haz = 1'b0;
      n.streak = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '{default: 0};
      m_b <= '{default: 0};
    end else begin
      m_a <= step(m_a, FC_A, CMAX_A, SL_A, lu, br, mb, clr);
      m_b <= step(m_b, FC_B, CMAX_B, SL_B, lu, br, mb, clr);
    end
  end

  // Compare process: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("a_ctl",       32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'(exp_ctl(m_a.pend, lu, br, mb)));
      chk("a_in_flush",  32'(a_inf), 32'(m_a.pend > 0));
      chk("a_stall_cnt", 32'(a_sc), 32'(m_a.sc));
      chk("a_flush_cnt", 32'(a_fc), 32'(m_a.fc));
      chk("a_haz_err",   32'(a_haz), 32'(m_a.haz));
      chk("b_ctl",       32'({b_pc, b_ifw, b_iff, b_bub, b_hold}), 32'(exp_ctl(m_b.pend, lu, br, mb)));
      chk("b_in_flush",  32'(b_inf), 32'(m_b.pend > 0));
      chk("b_stall_cnt", 32'(b_sc), 32'(m_b.sc));
      chk("b_flush_cnt", 32'(b_fc), 32'(m_b.fc));
      chk("b_haz_err",   32'(b_haz), 32'(m_b.haz));
    end
  end

  task automatic cyc(input bit l, input bit b, input bit m, input bit c);
    lu = l; br = b; mb = m; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lu = 0; br = 0; mb = 0; clr = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lu = 0; br = 0; mb = 0; clr = 0;
    do_reset();
    chk_en = 1'b1;

    // 1: reset state and idle
    #1;
    chk("t1_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h18);
    chk("t1_regs", 32'({a_inf, a_haz, a_sc, a_fc}), 32'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("t1_idle_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h18);

    // 2: single load-use stall
    lu = 1'b1;
    #1;
    chk("t2_stall_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h02);
    cyc(1, 0, 0, 0);
    chk("t2_stall_cnt", 32'(a_sc), 32'd1);
    chk("t2_haz", 32'(a_haz), 32'd0);
    cyc(0, 0, 0, 0);
    chk("t2_after_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h18);

    // 3: three-cycle flush, re-pulse ignored; FLUSH_CYCLES=1 instance counts both pulses
    do_reset();
    cyc(0, 1, 0, 0);
    chk("t3_in_flush_c2", 32'(a_inf), 32'd1);
    cyc(0, 1, 0, 0);
    chk("t3_in_flush_c3", 32'(a_inf), 32'd1);
    chk("t3_flush_ctl_c3", 32'(a_iff), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t3_in_flush_done", 32'(a_inf), 32'd0);
    chk("t3_flush_cnt", 32'(a_fc), 32'd1);
    chk("t3_b_flush_cnt", 32'(b_fc), 32'd2);

    // 4: busy in the middle of a flush extends it
    do_reset();
    cyc(0, 1, 0, 0);
    mb = 1'b1;
    #1;
    chk("t4_busy_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h01);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t4_in_flush_held", 32'(a_inf), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t4_in_flush_c4", 32'(a_inf), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t4_back_run", 32'(a_inf), 32'd0);
    chk("t4_stall_cnt", 32'(a_sc), 32'd2);

    // 5: loadUse beats brTaken, branch retried next cycle
    do_reset();
    lu = 1'b1; br = 1'b1;
    #1;
    chk("t5_both_ctl", 32'({a_pc, a_ifw, a_iff, a_bub, a_hold}), 32'h02);
    cyc(1, 1, 0, 0);
    chk("t5_no_flush_cnt", 32'(a_fc), 32'd0);
    cyc(0, 1, 0, 0);
    chk("t5_flush_cnt", 32'(a_fc), 32'd1);
    chk("t5_in_flush", 32'(a_inf), 32'd1);

    // mid-flush reset abandons the sequence immediately
    rst = 1'b1;
    #1;
    chk("t5_rst_in_flush", 32'(a_inf), 32'd0);
    chk("t5_rst_flush_cnt", 32'(a_fc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // 6: watchdog, clear, saturation
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t6_b_haz", 32'(b_haz), 32'd1);
    cyc(1, 0, 0, 0);
    chk("t6_haz_3", 32'(a_haz), 32'd0);
    cyc(1, 0, 0, 0);
    chk("t6_haz_4", 32'(a_haz), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t6_haz_sticky", 32'(a_haz), 32'd1);
    cyc(1, 0, 0, 1);
    chk("t6_clr_haz", 32'(a_haz), 32'd0);
    chk("t6_clr_stall", 32'(a_sc), 32'd0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    chk("t6_sat_a", 32'(a_sc), 32'd15);
    chk("t6_b_stall", 32'(b_sc), 32'd20);
    // busy during flush on the single-cycle instance and mixed traffic
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
